// File: rtl/axi_fifo_core.sv
// axi_fifo_core: synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Optional occupancy output 'level' is present only when AXI_FIFO_LEVEL_EN is defined.
module axi_fifo_core #(
  parameter int WIDTH     = 64,
  parameter int MIN_DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rdy_in,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  input  logic             rdy_out
`ifdef AXI_FIFO_LEVEL_EN
  ,
  output logic [$clog2(MIN_DEPTH):0] level
`endif
);
  localparam int LG    = $clog2(MIN_DEPTH);
  localparam int DEPTH = 2 ** LG;
  localparam int AW    = (LG > 0) ? LG : 1;
  localparam int CW    = LG + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Explicit wrap keeps the single-entry configuration correct as well.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rdy_in   = (r_count != CW'(DEPTH));
  assign vld_out  = (r_count != '0);
  assign w_push   = vld_in & rdy_in;
  assign w_pop    = vld_out & rdy_out;
  assign data_out = vld_out ? r_mem[r_rd_ptr] : '0;

`ifdef AXI_FIFO_LEVEL_EN
  assign level = r_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; stale words are hidden by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_axi_fifo_core.sv
// tb_axi_fifo_core: scoreboard bench for two FIFO configurations (64x16 and 8x8 from MIN_DEPTH=5).
// Build with AXI_FIFO_LEVEL_EN defined to also check the occupancy port.
module tb_axi_fifo_core;
  localparam int DA = 16;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_vld_in, a_rdy_in, a_vld_out, a_rdy_out;
  logic [63:0] a_data_in, a_data_out;
  logic        b_vld_in, b_rdy_in, b_vld_out, b_rdy_out;
  logic [7:0]  b_data_in, b_data_out;
`ifdef AXI_FIFO_LEVEL_EN
  logic [4:0]  a_level;
  logic [3:0]  b_level;
`endif

  axi_fifo_core #(.WIDTH(64), .MIN_DEPTH(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .vld_in(a_vld_in), .data_in(a_data_in), .rdy_in(a_rdy_in),
    .data_out(a_data_out), .vld_out(a_vld_out), .rdy_out(a_rdy_out)
`ifdef AXI_FIFO_LEVEL_EN
    , .level(a_level)
`endif
  );

  axi_fifo_core #(.WIDTH(8), .MIN_DEPTH(5)) u_dut_b (
    .clk(clk), .rst(rst),
    .vld_in(b_vld_in), .data_in(b_data_in), .rdy_in(b_rdy_in),
    .data_out(b_data_out), .vld_out(b_vld_out), .rdy_out(b_rdy_out)
`ifdef AXI_FIFO_LEVEL_EN
    , .level(b_level)
`endif
  );

  logic [63:0] qa[$];
  logic [7:0]  qb[$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on FIFO A: drive, check outputs against the model before the edge, update model.
  task automatic a_step(input bit v, input logic [63:0] d, input bit r);
    bit push, pop;
    a_vld_in = v; a_data_in = d; a_rdy_out = r;
    @(negedge clk);
    chk_val("a_rdy_in", 64'(a_rdy_in), 64'(qa.size() != DA));
    chk_val("a_vld_out", 64'(a_vld_out), 64'(qa.size() != 0));
    if (qa.size() != 0) chk_val("a_data_out", a_data_out, qa[0]);
    else                chk_val("a_data_out_empty", a_data_out, 64'd0);
`ifdef AXI_FIFO_LEVEL_EN
    chk_val("a_level", 64'(a_level), 64'(qa.size()));
`endif
    push = v && (qa.size() != DA);
    pop  = r && (qa.size() != 0);
    if (pop)  void'(qa.pop_front());
    if (push) qa.push_back(d);
    @(posedge clk); #1;
    a_vld_in = 1'b0; a_rdy_out = 1'b0;
  endtask

  task automatic b_step(input bit v, input logic [7:0] d, input bit r);
    bit push, pop;
    b_vld_in = v; b_data_in = d; b_rdy_out = r;
    @(negedge clk);
    chk_val("b_rdy_in", 64'(b_rdy_in), 64'(qb.size() != DB));
    chk_val("b_vld_out", 64'(b_vld_out), 64'(qb.size() != 0));
    if (qb.size() != 0) chk_val("b_data_out", 64'(b_data_out), 64'(qb[0]));
    else                chk_val("b_data_out_empty", 64'(b_data_out), 64'd0);
`ifdef AXI_FIFO_LEVEL_EN
    chk_val("b_level", 64'(b_level), 64'(qb.size()));
`endif
    push = v && (qb.size() != DB);
    pop  = r && (qb.size() != 0);
    if (pop)  void'(qb.pop_front());
    if (push) qb.push_back(d);
    @(posedge clk); #1;
    b_vld_in = 1'b0; b_rdy_out = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1;
    a_vld_in = 0; a_rdy_out = 0; a_data_in = '0;
    b_vld_in = 0; b_rdy_out = 0; b_data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on both instances.
    a_step(0, '0, 0);
    b_step(0, '0, 0);

    // Fill A to full, offer one more word while full, then drain in order.
    for (int i = 0; i < DA; i++) a_step(1, rnd64(), 0);
    a_step(1, 64'hDEAD_BEEF_0BAD_F00D, 0);
    for (int i = 0; i < DA; i++) a_step(0, '0, 1);
    a_step(0, '0, 0);

    // B: depth rounds 5 up to 8; 8'hFF offered while full must never appear.
    for (int i = 0; i < DB; i++) b_step(1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 3; i++)  b_step(1, 8'hFF, 0);
    for (int i = 0; i < DB; i++) b_step(0, '0, 1);
    b_step(0, '0, 0);

    // B: pop attempt on empty, then normal traffic still works.
    b_step(0, '0, 1);
    b_step(0, '0, 0);
    b_step(1, 8'hA5, 0);
    b_step(1, 8'h5A, 1);
    b_step(0, '0, 1);
    b_step(0, '0, 1);

    // A: move pointers near the wrap point, then interleaved push/pop across it.
    for (int i = 0; i < 14; i++) a_step(1, rnd64(), 1);
    a_step(0, '0, 1);
    for (int i = 0; i < 3; i++) a_step(1, rnd64(), 0);
    for (int i = 0; i < 2; i++) a_step(0, '0, 1);
    for (int i = 0; i < 4; i++) a_step(1, rnd64(), 0);
    for (int i = 0; i < 5; i++) a_step(0, '0, 1);
    a_step(0, '0, 0);

    // A: simultaneous push/pop with two held, then at full (pop only).
    a_step(1, rnd64(), 0);
    a_step(1, rnd64(), 0);
    for (int i = 0; i < 6; i++) a_step(1, rnd64(), 1);
    for (int i = 0; i < DA - 2; i++) a_step(1, rnd64(), 0);
    a_step(1, 64'hFFFF_0000_FFFF_0000, 1);
    a_step(0, '0, 0);
    for (int i = 0; i < DA; i++) a_step(0, '0, 1);

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      a_step(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)));
      b_step(1'($urandom_range(0, 3) != 0), 8'($urandom()), 1'($urandom_range(0, 3) == 0));
    end

    // Reset mid-stream with words stored and a push offered on the reset edge.
    for (int i = 0; i < 3; i++) a_step(1, rnd64(), 0);
    a_vld_in = 1'b1; a_data_in = rnd64(); b_vld_in = 1'b1; b_data_in = 8'h77;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_vld_in = 1'b0; b_vld_in = 1'b0;
    qa.delete(); qb.delete();
    a_step(0, '0, 1);
    b_step(0, '0, 1);
    a_step(1, 64'h0123_4567_89AB_CDEF, 0);
    a_step(0, '0, 1);
    a_step(0, '0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
